// File: rtl/serial_word_packer_if.sv
// Handshake bundle between the serial bit source, the word packer and the
// comma-code index stage.
//   bit_in, bit_valid, bit_ready : serial bit stream, accepted on valid && ready
//   word_out, word_valid, word_ready : packed word, taken on valid && ready
//   seq_count : overlapping "101" count belonging to word_out
//   overflow  : sticky flag, a bit was offered while the packer could not take it
// slave  : packer side (consumes bits, produces words)
// master : environment side (produces bits, consumes words)
interface serial_word_packer_if #(
    parameter int word_size  = 16,
    parameter int count_size = 4
);
    logic                  bit_in;
    logic                  bit_valid;
    logic                  bit_ready;
    logic [word_size-1:0]  word_out;
    logic                  word_valid;
    logic                  word_ready;
    logic [count_size-1:0] seq_count;
    logic                  overflow;

    modport slave (
        input  bit_in, bit_valid, word_ready,
        output bit_ready, word_out, word_valid, seq_count, overflow
    );

    modport master (
        output bit_in, bit_valid, word_ready,
        input  bit_ready, word_out, word_valid, seq_count, overflow
    );
endinterface

// File: rtl/serial_word_packer.sv
// Packs a serial bit stream, MSB first, into word_size-bit words for the
// comma-code index stage and counts overlapping "101" occurrences inside
// each word while it is being packed.
// Ports:
//   clk   : single clock, all logic on posedge
//   reset : synchronous, active-high; discards any partial word
//   bus   : serial_word_packer_if.slave (bit stream in, word + count out,
//           sticky overflow)
//
// state | meaning
// ------+-------------------------------------------------------------
// FILL  | collecting bits, bit_ready=1
// HOLD  | complete word presented; bit_ready follows word_ready so a new
//       | bit can enter in the same cycle the word is taken
module serial_word_packer #(
    parameter int word_size  = 16,
    parameter int index_size = 4,
    parameter int count_size = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_word_packer_if.slave    bus
);
    localparam logic [0:0] STATE_FILL = 1'b0;
    localparam logic [0:0] STATE_HOLD = 1'b1;

    localparam logic [index_size-1:0] LAST_IDX = index_size'(word_size - 1);
    localparam logic [index_size-1:0] IDX_TWO  = index_size'(2);
    localparam logic [count_size-1:0] CNT_MAX  = '1;

    logic [0:0]            state_q,      state_d;
    logic [index_size-1:0] bit_cnt_q,    bit_cnt_d;
    logic [word_size-1:0]  shift_q,      shift_d;
    logic                  prev1_q,      prev1_d;
    logic                  prev2_q,      prev2_d;
    logic [count_size-1:0] run_cnt_q,    run_cnt_d;
    logic [word_size-1:0]  word_out_q,   word_out_d;
    logic                  word_valid_q, word_valid_d;
    logic [count_size-1:0] seq_count_q,  seq_count_d;
    logic                  overflow_q,   overflow_d;

    logic                  bit_ready;
    logic                  accept;
    logic                  hit;
    logic [count_size-1:0] cnt_acc;
    logic [word_size-1:0]  shift_acc;

    assign bit_ready = (state_q == STATE_FILL) || bus.word_ready;
    assign accept    = bus.bit_valid && bit_ready;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        prev1_d      = prev1_q;
        prev2_d      = prev2_q;
        run_cnt_d    = run_cnt_q;
        word_out_d   = word_out_q;
        word_valid_d = word_valid_q;
        seq_count_d  = seq_count_q;
        overflow_d   = overflow_q;

        // The index >= 2 gate keeps a pattern from spanning two words, so
        // prev1/prev2 never need an explicit clear at word start.
        hit       = bus.bit_in && !prev1_q && prev2_q && (bit_cnt_q >= IDX_TWO);
        shift_acc = {shift_q[word_size-2:0], bus.bit_in};

        if (bit_cnt_q == '0) begin
            cnt_acc = '0;
        end else if (hit && (run_cnt_q != CNT_MAX)) begin
            cnt_acc = run_cnt_q + count_size'(1);
        end else begin
            cnt_acc = run_cnt_q;
        end

        if ((state_q == STATE_HOLD) && bus.word_ready) begin
            word_valid_d = 1'b0;
            state_d      = STATE_FILL;
        end

        if (accept) begin
            shift_d   = shift_acc;
            prev2_d   = prev1_q;
            prev1_d   = bus.bit_in;
            run_cnt_d = cnt_acc;
            if (bit_cnt_q == LAST_IDX) begin
                word_out_d   = shift_acc;
                seq_count_d  = cnt_acc;
                word_valid_d = 1'b1;
                bit_cnt_d    = '0;
                state_d      = STATE_HOLD;
            end else begin
                bit_cnt_d = bit_cnt_q + index_size'(1);
            end
        end

        if (bus.bit_valid && !bit_ready) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= STATE_FILL;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            prev1_q      <= 1'b0;
            prev2_q      <= 1'b0;
            run_cnt_q    <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            seq_count_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            prev1_q      <= prev1_d;
            prev2_q      <= prev2_d;
            run_cnt_q    <= run_cnt_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            seq_count_q  <= seq_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.bit_ready  = bit_ready;
    assign bus.word_out   = word_out_q;
    assign bus.word_valid = word_valid_q;
    assign bus.seq_count  = seq_count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_serial_word_packer.sv
// Bench for serial_word_packer: words are pushed to a scoreboard as they are
// streamed in, and popped/compared when the packer hands them downstream.
module tb_serial_word_packer;
    localparam int WS = 16;
    localparam int IS = 4;
    localparam int CS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    serial_word_packer_if #(.word_size(WS), .count_size(CS)) bus ();

    serial_word_packer #(
        .word_size (WS),
        .index_size(IS),
        .count_size(CS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [WS-1:0] word;
        logic [CS-1:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_e;
    int   checks     = 0;
    int   errors     = 0;
    int   stalls     = 0;
    int   vld_cycles = 0;

    // Independent reference: scan every 3-bit window wholly inside the word.
    function automatic logic [CS-1:0] model_count(input logic [WS-1:0] w);
        int n;
        n = 0;
        for (int p = WS - 1; p >= 2; p--) begin
            if (w[p] && !w[p-1] && w[p-2]) n++;
        end
        return CS'(n);
    endfunction

    // Word taken at the next posedge whenever valid && ready at mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.word_valid) vld_cycles++;
            if (!reset && bus.word_valid && bus.word_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got word %h, required no word", bus.word_out);
                end else begin
                    exp_e = sb_q.pop_front();
                    if (bus.word_out !== exp_e.word) begin
                        errors++;
                        $display("FAIL sb_word: got %h, required %h", bus.word_out, exp_e.word);
                    end
                    checks++;
                    if (bus.seq_count !== exp_e.cnt) begin
                        errors++;
                        $display("FAIL sb_count (word %h): got %0d, required %0d",
                                 exp_e.word, bus.seq_count, exp_e.cnt);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        bit ok;
        ok = 1'b0;
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.bit_ready) begin
                ok = 1'b1;
                break;
            end
            stalls++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL bit_accept_timeout: bit_ready got 0, required 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_word(input logic [WS-1:0] w);
        sb_q.push_back('{word: w, cnt: model_count(w)});
        for (int i = WS - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 100; k++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d words pending, required 0", name, sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.word_out !== '0) begin
            errors++; $display("FAIL rst_word_out: got %h, required 0", bus.word_out);
        end
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL rst_word_valid: got %b, required 0", bus.word_valid);
        end
        checks++;
        if (bus.seq_count !== '0) begin
            errors++; $display("FAIL rst_seq_count: got %0d, required 0", bus.seq_count);
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++; $display("FAIL rst_overflow: got %b, required 0", bus.overflow);
        end
        checks++;
        if (bus.bit_ready !== 1'b1) begin
            errors++; $display("FAIL rst_bit_ready: got %b, required 1", bus.bit_ready);
        end
    endtask

    task automatic test_basic();
        bus.word_ready = 1'b1;
        send_word(16'h0005);
        // word_valid is already up just after the edge that took bit 16
        checks++;
        if (bus.word_valid !== 1'b1) begin
            errors++; $display("FAIL basic_latency: word_valid got %b, required 1", bus.word_valid);
        end
        checks++;
        if (bus.word_out !== 16'h0005) begin
            errors++; $display("FAIL basic_word: got %h, required 0005", bus.word_out);
        end
        checks++;
        if (bus.seq_count !== 4'd1) begin
            errors++; $display("FAIL basic_count: got %0d, required 1", bus.seq_count);
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++; $display("FAIL basic_overflow: got %b, required 0", bus.overflow);
        end
        wait_drain("basic");
    endtask

    task automatic test_patterns();
        bus.word_ready = 1'b1;
        send_word(16'hAAAA);
        checks++;
        if (bus.seq_count !== 4'd7) begin
            errors++; $display("FAIL pat_aaaa_count: got %0d, required 7", bus.seq_count);
        end
        wait_drain("aaaa");
        send_word(16'h0000);
        checks++;
        if (bus.seq_count !== 4'd0) begin
            errors++; $display("FAIL pat_zero_count: got %0d, required 0", bus.seq_count);
        end
        wait_drain("zero");
    endtask

    task automatic test_back_to_back();
        bus.word_ready = 1'b1;
        stalls     = 0;
        vld_cycles = 0;
        send_word(16'h0AA0);
        send_word(16'hA00F);
        wait_drain("b2b");
        checks++;
        if (stalls !== 0) begin
            errors++; $display("FAIL b2b_stalls: got %0d, required 0", stalls);
        end
        checks++;
        if (vld_cycles !== 2) begin
            errors++; $display("FAIL b2b_valid_cycles: got %0d, required 2", vld_cycles);
        end
    endtask

    task automatic test_overflow();
        bus.word_ready = 1'b0;
        send_word(16'hF50F);
        checks++;
        if (bus.word_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_valid: got %b, required 1", bus.word_valid);
        end
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.bit_ready !== 1'b0) begin
                errors++; $display("FAIL ovf_bit_ready[%0d]: got %b, required 0", k, bus.bit_ready);
            end
            checks++;
            if (bus.word_out !== 16'hF50F) begin
                errors++; $display("FAIL ovf_hold_word[%0d]: got %h, required f50f", k, bus.word_out);
            end
            @(posedge clk);
            #1;
        end
        bus.bit_valid = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_set: got %b, required 1", bus.overflow);
        end
        bus.word_ready = 1'b1;
        wait_drain("ovf");
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky: got %b, required 1", bus.overflow);
        end
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_consumed: word_valid got %b, required 0", bus.word_valid);
        end
    endtask

    task automatic test_cross_word();
        bus.word_ready = 1'b1;
        send_word(16'h0002);
        wait_drain("cross1");
        send_word(16'h8000);
        checks++;
        if (bus.seq_count !== 4'd0) begin
            errors++; $display("FAIL cross_count: got %0d, required 0", bus.seq_count);
        end
        wait_drain("cross2");
    endtask

    task automatic test_reset_mid_word();
        logic [WS-1:0] w;
        bus.word_ready = 1'b1;
        for (int i = 0; i < 9; i++) send_bit(i[0] ? 1'b0 : 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.word_out !== '0) begin
            errors++; $display("FAIL mid_rst_word_out: got %h, required 0", bus.word_out);
        end
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++; $display("FAIL mid_rst_word_valid: got %b, required 0", bus.word_valid);
        end
        checks++;
        if (bus.seq_count !== '0) begin
            errors++; $display("FAIL mid_rst_seq_count: got %0d, required 0", bus.seq_count);
        end
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++; $display("FAIL mid_rst_overflow: got %b, required 0", bus.overflow);
        end
        w = 16'h0AB7;
        send_word(w);
        checks++;
        if (bus.word_out !== w) begin
            errors++; $display("FAIL mid_word: got %h, required %h", bus.word_out, w);
        end
        checks++;
        if (bus.seq_count !== model_count(w)) begin
            errors++; $display("FAIL mid_count: got %0d, required %0d", bus.seq_count, model_count(w));
        end
        wait_drain("mid");
    endtask

    initial begin
        bus.bit_in     = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.word_ready = 1'b0;
        reset          = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        test_reset();
        test_basic();
        test_patterns();
        test_back_to_back();
        test_overflow();
        test_cross_word();
        test_reset_mid_word();

        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d words, required 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
